bit64_subtractor: RTL and testbench
===================================

BIT64_SUBTRACTOR -- requirements
Module: bit64_subtractor

Interface
REQ-001 SHALL have parameter W, default 64, operand/result width in bits; legal values are even, 8..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-006 SHALL have port in1, input signed, W, minuend: the desired/reference sample.
REQ-007 SHALL have port in2, input signed, W, subtrahend: the filter-output sample.
REQ-008 SHALL have port out_valid, output, 1, out1 and ovf are valid this cycle.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result this cycle.
REQ-010 SHALL have port out1, output signed, W, difference in1 - in2.
REQ-011 SHALL have port ovf, output, 1, signed overflow occurred for this result.

Function
REQ-012 SHALL transfer on an input when in_valid && in_ready, and on an output when out_valid && out_ready.
REQ-013 SHALL compute the result in a 2-stage pipeline.
- Stage 1: low W/2 bits of in1 + ~in2 + 1; registers the low result, the carry-out, and the high halves of both operands.
- Stage 2: high W/2 bits with the stage-1 carry; registers out1 and ovf.
REQ-014 SHALL have a latency of exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-015 SHALL sustain throughput of 1 result per cycle when out_ready is held high.
REQ-016 SHALL advance stage 2 when !out_valid || out_ready.
REQ-017 SHALL advance stage 1 when !s1_valid || stage 2 advances; in_ready equals this stage-1 advance condition.
REQ-018 SHALL hold out1, ovf and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL lose and duplicate no data under any in_valid/out_ready pattern.
REQ-020 SHALL set ovf = (in1[W-1] != in2[W-1]) && (raw_result[W-1] != in1[W-1]).
REQ-021 SHALL wrap the raw result modulo 2^W when saturation is disabled.
REQ-022 SHALL handle these boundary cases:
- MIN - 1: ovf=1.
- 0 - MIN: ovf=1.
- MIN - MIN: result 0, ovf=0.
REQ-023 SHALL allow a simultaneous input and output transfer in the same cycle, with no bubble.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear s1_valid and out_valid, and clear out1 and ovf to 0.
REQ-025 SHALL drive in_ready=1 during and after reset.
REQ-026 SHALL discard data in flight when reset is asserted mid-operation; no result for it appears after reset.

Configuration
REQ-027 SHALL, when BIT64_SUBTRACTOR_SAT_EN is defined, drive out1 on ovf=1 as follows:
- 2^(W-1)-1 if in1 is non-negative.
- -2^(W-1) if in1 is negative.
REQ-028 SHALL, when BIT64_SUBTRACTOR_SAT_EN is undefined, output the wrapped result; ovf is still reported.

Structure
REQ-029 SHALL place the following in shared package anc_arith_pkg:
- typedef sample64_t (signed 64-bit).
- constants SAMPLE64_MAX and SAMPLE64_MIN.
REQ-030 SHALL use one sub-module, sub_half_stage: a W/2-bit subtract-with-carry slice instantiated once per stage.

Verification
REQ-031 SHALL cover in1=100, in2=30, out_ready=1 -> out1=70, ovf=0, out_valid exactly 2 cycles after the input transfer.
REQ-032 SHALL cover in1=0x0000_0001_0000_0000, in2=1 -> out1=0x0000_0000_FFFF_FFFF (borrow across the half boundary).
REQ-033 SHALL cover in1=SAMPLE64_MIN, in2=1:
- Without SAT_EN: out1=SAMPLE64_MAX, ovf=1.
- With SAT_EN: out1=SAMPLE64_MIN, ovf=1.
REQ-034 SHALL cover 1000 random back-to-back pairs with out_ready toggling randomly -> results in order, match the reference model, in_ready low only when both stages are full and stalled.
REQ-035 SHALL cover rst asserted with 2 items in flight -> out_valid=0 next cycle, neither item ever emitted.
REQ-036 SHALL cover in1=SAMPLE64_MIN, in2=SAMPLE64_MIN -> out1=0, ovf=0.

Source files
------------

// File: rtl/anc_arith_pkg.sv
// Shared arithmetic types and limits for the ANC datapath.
package anc_arith_pkg;

    typedef logic signed [63:0] sample64_t;

    localparam sample64_t SAMPLE64_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam sample64_t SAMPLE64_MIN = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/sub_half_stage.sv
// Half-width subtract-with-carry slice: {cout, diff} = a + ~b + cin.
module sub_half_stage #(
    parameter int unsigned HW = 32
) (
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    input  logic          cin,
    output logic [HW-1:0] diff,
    output logic          cout
);

    always_comb begin
        {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{HW{1'b0}}, cin};
    end

endmodule

// File: rtl/bit64_subtractor.sv
// Two-stage pipelined signed subtractor out1 = in1 - in2 with valid/ready handshakes.
// Define BIT64_SUBTRACTOR_SAT_EN to saturate out1 on signed overflow instead of wrapping.
module bit64_subtractor
    import anc_arith_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out1,
    output logic                ovf
);

    localparam int unsigned H = W / 2;

    logic         s1_valid_q;
    logic [H-1:0] s1_lo_q;
    logic         s1_carry_q;
    logic [H-1:0] s1_a_hi_q;
    logic [H-1:0] s1_b_hi_q;
    logic         out_valid_q;
    logic [W-1:0] out1_q;
    logic         ovf_q;

    logic         s1_adv;
    logic         s2_adv;
    logic [H-1:0] lo_diff;
    logic         lo_cout;
    logic [H-1:0] hi_diff;
    logic         hi_cout;
    logic         wide_msb;
    logic         ovf_d;
    logic [W-1:0] out1_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rst || s1_adv;

    sub_half_stage #(
        .HW (H)
    ) u_lo (
        .a    (in1[H-1:0]),
        .b    (in2[H-1:0]),
        .cin  (1'b1),
        .diff (lo_diff),
        .cout (lo_cout)
    );

    sub_half_stage #(
        .HW (H)
    ) u_hi (
        .a    (s1_a_hi_q),
        .b    (s1_b_hi_q),
        .cin  (s1_carry_q),
        .diff (hi_diff),
        .cout (hi_cout)
    );

`ifdef BIT64_SUBTRACTOR_SAT_EN
    localparam logic [W-1:0] SatMax = W'(SAMPLE64_MAX >>> (64 - W));
    localparam logic [W-1:0] SatMin = W'(SAMPLE64_MIN >>> (64 - W));
`endif

    // wide_msb is the sign of the exact (W+1)-bit difference; it equals in1's sign
    // whenever the operand signs differ, which is the only case ovf can be set.
    always_comb begin
        wide_msb = s1_a_hi_q[H-1] ^ ~s1_b_hi_q[H-1] ^ hi_cout;
        ovf_d    = (s1_a_hi_q[H-1] != s1_b_hi_q[H-1]) && (hi_diff[H-1] != wide_msb);
        out1_d   = {hi_diff, s1_lo_q};
`ifdef BIT64_SUBTRACTOR_SAT_EN
        if (ovf_d) begin
            out1_d = wide_msb ? SatMin : SatMax;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_lo_q    <= lo_diff;
                    s1_carry_q <= lo_cout;
                    s1_a_hi_q  <= in1[W-1:H];
                    s1_b_hi_q  <= in2[W-1:H];
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out1_q <= out1_d;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out1      = out1_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit64_subtractor.sv
// Self-checking bench for bit64_subtractor: directed corners, randomized traffic, mid-flight reset.
module tb_bit64_subtractor;

    localparam int unsigned W = 64;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in1 = '0;
    logic signed [W-1:0] in2 = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out1;
    logic                ovf;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    bit64_subtractor #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact difference in W+1 bits; overflow when it does not fit in W bits.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] d;
        exp_t r;
        d = $signed({a[63], a}) - $signed({b[63], b});
        r.ovf = (d[64] != d[63]);
        r.res = d[63:0];
`ifdef BIT64_SUBTRACTOR_SAT_EN
        if (r.ovf) r.res = d[64] ? MINV : MAXV;
`endif
        return r;
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return MINV;
            1:       return MAXV;
            2:       return 64'd0;
            3:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Handshakes seen at the falling edge are the transfers of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check_eq("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out1", out1, mon_e.res);
                    check_eq("ovf", 64'(ovf), 64'(mon_e.ovf));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2));
        end
    end

    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_res, input logic exp_ovf);
        @(posedge clk); #1;
        in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq({tag, "_lat2"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_out1"}, out1, exp_res);
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        @(posedge clk); #1;
    endtask

    initial begin
        int  sent;
        int  cyc;
        bit  xfer;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out1", out1, 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        directed("basic", 64'd100, 64'd30, 64'd70, 1'b0);
        directed("borrow", 64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0);
`ifdef BIT64_SUBTRACTOR_SAT_EN
        directed("min_m1", MINV, 64'd1, MINV, 1'b1);
        directed("zero_mmin", 64'd0, MINV, MAXV, 1'b1);
        directed("max_mneg1", MAXV, '1, MAXV, 1'b1);
`else
        directed("min_m1", MINV, 64'd1, MAXV, 1'b1);
        directed("zero_mmin", 64'd0, MINV, MINV, 1'b1);
        directed("max_mneg1", MAXV, '1, MINV, 1'b1);
`endif
        directed("min_mmin", MINV, MINV, 64'd0, 1'b0);

        // Randomized back-to-back traffic with a randomly stalling sink.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            if (xfer) sent++;
            @(posedge clk); #1;
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (xfer || !in_valid) begin
                if (sent < 1000 && $urandom_range(0, 7) != 0) begin
                    in_valid = 1'b1;
                    in1 = rand_val();
                    in2 = rand_val();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_eq("rand_sent", 64'(sent), 64'd1000);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_out_valid", 64'(out_valid), 64'd0);

        // Fill both stages against a stalled sink, then reset.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in1 = 64'd5; in2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = 64'd7; in2 = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        check_eq("full_depth", 64'(exp_q.size()), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_out1", out1, 64'd0);
        check_eq("rst_mid_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_no_ghost", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
